dac_mode_sequencer: RTL and testbench

//  Control-plane sequencer in front of the DAC sample generator. It turns PS mode requests
//  (idle/random/triangle/PWL) into the generator's one-cycle command pulses.
//  - Safe order for every mode change: halt -> drain the DAC output pipeline -> wait for PWL

---
 rtl/dac_seq_pkg.sv | 30 +++
 rtl/dac_mode_sequencer.sv | 157 +++++++++++++++
 tb/tb_dac_mode_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared types and gen_cmd bit map for the DAC mode sequencer
package dac_seq_pkg;

  // PS-visible mode encoding
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RAND = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_PWL  = 2'd3
  } dac_mode_t;

  // Sequencer states: halt -> settle -> (wait_pwl) -> run -> active
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HALT     = 3'd1,
    SETTLE   = 3'd2,
    WAIT_PWL = 3'd3,
    RUN      = 3'd4,
    ACTIVE   = 3'd5
  } seq_state_t;

  // Low control bits of gen_cmd; the seed sits above them
  localparam int CMD_PWL  = 0;
  localparam int CMD_TRIG = 1;
  localparam int CMD_RAND = 2;
  localparam int CMD_HALT = 3;
  localparam int CMD_RST  = 4;
  localparam int CMD_W    = 5;

endpackage

// File: rtl/dac_mode_sequencer.sv
// rtl/dac_mode_sequencer.sv - mode-change sequencer for the DAC generator (optional PWL_TIMEOUT_EN)
module dac_mode_sequencer
  import dac_seq_pkg::*;
#(
  parameter int BATCH_WIDTH   = 256,
  parameter int SETTLE_CYCLES = 8,
  parameter int PWL_TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   rst_in_n,
  input  logic [1:0]             req_mode,
  input  logic [BATCH_WIDTH-1:0] req_seed,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [BATCH_WIDTH+4:0] gen_cmd,
  output logic                   gen_cmd_valid,
  input  logic                   dac_cmd,
  input  logic                   dac_cmd_valid,
  output logic [1:0]             active_mode,
  output logic                   busy,
  output logic                   err_timeout
);

  // One counter serves both the settle countdown and the PWL wait count
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  dac_mode_t              mode_q, mode_d;
  logic [BATCH_WIDTH-1:0] seed_q, seed_d;
  dac_mode_t              active_q, active_d;
  logic                   pwl_rdy_q, pwl_rdy_d;

`ifdef PWL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PWL_TIMEOUT - 1);
  logic err_q, err_d;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign active_mode = active_q;

  // Next-state, command pulses and handshake outputs decoded from the current state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    seed_d        = seed_q;
    active_d      = active_q;
    gen_cmd       = '0;
    gen_cmd_valid = 1'b0;
    req_ready     = 1'b0;
    busy          = 1'b0;
    // Readiness is evaluated on the value being loaded this cycle
    pwl_rdy_d     = dac_cmd_valid ? dac_cmd : pwl_rdy_q;
`ifdef PWL_TIMEOUT_EN
    err_d         = err_q;
`endif

    case (state_q)
      IDLE, ACTIVE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mode_d  = dac_mode_t'(req_mode);
          seed_d  = req_seed;
          state_d = HALT;
`ifdef PWL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      HALT: begin
        busy              = 1'b1;
        gen_cmd_valid     = 1'b1;
        gen_cmd[CMD_HALT] = 1'b1;
        active_d          = MODE_IDLE;
        cnt_d             = SETTLE_LOAD;
        state_d           = SETTLE;
      end

      SETTLE: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          case (mode_q)
            MODE_IDLE: state_d = IDLE;
            MODE_PWL:  state_d = WAIT_PWL;
            default:   state_d = RUN;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WAIT_PWL: begin
        busy = 1'b1;
        if (pwl_rdy_d) begin
          state_d = RUN;
        end
`ifdef PWL_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RUN: begin
        busy          = 1'b1;
        gen_cmd_valid = 1'b1;
        case (mode_q)
          MODE_RAND: begin
            gen_cmd[BATCH_WIDTH+4:CMD_W] = seed_q;
            gen_cmd[CMD_RAND]            = 1'b1;
          end
          MODE_TRIG: gen_cmd[CMD_TRIG] = 1'b1;
          MODE_PWL:  gen_cmd[CMD_PWL]  = 1'b1;
          default:   gen_cmd           = '0;
        endcase
        active_d = mode_q;
        state_d  = ACTIVE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops straight back to IDLE with no pulses
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= MODE_IDLE;
      seed_q    <= '0;
      active_q  <= MODE_IDLE;
      pwl_rdy_q <= 1'b0;
`ifdef PWL_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      active_q  <= active_d;
      pwl_rdy_q <= pwl_rdy_d;
`ifdef PWL_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// tb/tb_dac_mode_sequencer.sv - randomized check of dac_mode_sequencer against a timeline model
module tb_dac_mode_sequencer;

  localparam int BW = 256;
  localparam int S  = 8;
`ifdef PWL_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst_in_n;
  logic [1:0]    req_mode;
  logic [BW-1:0] req_seed;
  logic          req_valid;
  logic          req_ready;
  logic [BW+4:0] gen_cmd;
  logic          gen_cmd_valid;
  logic          dac_cmd;
  logic          dac_cmd_valid;
  logic [1:0]    active_mode;
  logic          busy;
  logic          err_timeout;

  dac_mode_sequencer #(
    .BATCH_WIDTH  (BW),
    .SETTLE_CYCLES(S),
    .PWL_TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst_in_n     (rst_in_n),
    .req_mode     (req_mode),
    .req_seed     (req_seed),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .gen_cmd      (gen_cmd),
    .gen_cmd_valid(gen_cmd_valid),
    .dac_cmd      (dac_cmd),
    .dac_cmd_valid(dac_cmd_valid),
    .active_mode  (active_mode),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Timeline model: one mode change is described by the cycle of its halt
  // pulse and the cycle its busy window ends (unknown while waiting on PWL).
  bit            m_seq;
  int            m_halt;
  bit            m_end_known;
  int            m_end;
  bit            m_has_run;
  logic [1:0]    m_mode;
  logic [BW-1:0] m_seed;
  logic [1:0]    m_prev_act;
  bit            m_rdy;
  bit            m_err;

  task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_busy();
    return m_seq && cyc >= m_halt && (!m_end_known || cyc <= m_end);
  endfunction

  function automatic bit is_run_cycle();
    return m_seq && m_has_run && m_end_known && cyc == m_end;
  endfunction

  function automatic bit exp_valid();
    return (m_seq && cyc == m_halt) || is_run_cycle();
  endfunction

  function automatic logic [BW+4:0] exp_cmd();
    logic [BW+4:0] c;
    c = '0;
    if (m_seq && cyc == m_halt) c[3] = 1'b1;
    else if (is_run_cycle()) begin
      case (m_mode)
        2'd1: c = {m_seed, 5'b00100};
        2'd2: c[1] = 1'b1;
        2'd3: c[0] = 1'b1;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  function automatic logic [1:0] exp_act();
    if (!m_seq) return 2'd0;
    if (m_end_known && cyc > m_end) return m_has_run ? m_mode : 2'd0;
    if (cyc > m_halt) return 2'd0;
    return m_prev_act;
  endfunction

  task automatic check_outputs();
    check("gen_cmd_valid", gen_cmd_valid, exp_valid());
    check("gen_cmd", gen_cmd, exp_cmd());
    check("req_ready", req_ready, !exp_busy());
    check("busy", busy, exp_busy());
    check("active_mode", active_mode, exp_act());
    check("err_timeout", err_timeout, m_err);
  endtask

  // Apply this cycle's inputs to the model at the upcoming clock edge
  task automatic advance();
    bit rdy_eff;
    int wait_start;
    rdy_eff    = dac_cmd_valid ? dac_cmd : m_rdy;
    wait_start = m_halt + S + 1;
    if (m_seq && m_mode == 2'd3 && !m_end_known && cyc >= wait_start) begin
      if (rdy_eff) begin
        m_end = cyc + 1; m_end_known = 1'b1; m_has_run = 1'b1;
      end
`ifdef PWL_TIMEOUT_EN
      else if (cyc == wait_start + TO - 1) begin
        m_end = cyc; m_end_known = 1'b1; m_has_run = 1'b0; m_err = 1'b1;
      end
`endif
    end
    if (req_valid && !exp_busy()) begin
      m_prev_act = exp_act();
      m_seq      = 1'b1;
      m_halt     = cyc + 1;
      m_mode     = req_mode;
      m_seed     = req_seed;
      m_err      = 1'b0;
      case (req_mode)
        2'd0:    begin m_end_known = 1'b1; m_end = m_halt + S;     m_has_run = 1'b0; end
        2'd3:    begin m_end_known = 1'b0; m_end = 0;              m_has_run = 1'b0; end
        default: begin m_end_known = 1'b1; m_end = m_halt + S + 1; m_has_run = 1'b1; end
      endcase
    end
    m_rdy = rdy_eff;
  endtask

  task automatic model_reset();
    m_seq = 1'b0; m_halt = 0; m_end_known = 1'b0; m_end = 0; m_has_run = 1'b0;
    m_mode = 2'd0; m_seed = '0; m_prev_act = 2'd0; m_rdy = 1'b0; m_err = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive_req(input logic [1:0] mode, input logic [BW-1:0] seed);
    req_valid = 1'b1; req_mode = mode; req_seed = seed;
    cycle();
    req_valid = 1'b0;
  endtask

  function automatic logic [BW-1:0] rand_seed();
    logic [BW-1:0] s;
    for (int i = 0; i < BW / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_gen_cmd_valid"}, gen_cmd_valid, 1'b0);
    check({pfx, "_gen_cmd"}, gen_cmd, '0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_active_mode"}, active_mode, 2'd0);
    check({pfx, "_err_timeout"}, err_timeout, 1'b0);
    check({pfx, "_req_ready"}, req_ready, 1'b1);
  endtask

  // Assert reset mid-cycle, confirm outputs clear immediately, release after an edge
  task automatic do_reset();
    req_valid = 1'b0;
    #2;
    rst_in_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_in_n = 1'b1;
    cyc++;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_in_n = 1'b0; req_mode = '0; req_seed = '0; req_valid = 1'b0;
    dac_cmd = 1'b0; dac_cmd_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_in_n = 1'b1;

    // triangle: halt at cycle 1, run at cycle 1+S+1
    drive_req(2'd2, '0);
    idle(15);

    // random mode carries the seed on the run pulse
    drive_req(2'd1, BW'(256'hA5));
    idle(15);

    // PWL gating: not ready, then readiness arrives
    dac_cmd_valid = 1'b1; dac_cmd = 1'b0;
    cycle();
    dac_cmd_valid = 1'b0;
    drive_req(2'd3, '0);
    idle(30);
    dac_cmd_valid = 1'b1; dac_cmd = 1'b1;
    cycle();
    dac_cmd_valid = 1'b0;
    idle(4);

`ifdef PWL_TIMEOUT_EN
    dac_cmd_valid = 1'b1; dac_cmd = 1'b0;
    cycle();
    dac_cmd_valid = 1'b0;
    drive_req(2'd3, '0);
    idle(40);
    drive_req(2'd2, '0);
    idle(15);
`endif

    // request held while busy is only taken once ACTIVE
    drive_req(2'd2, '0);
    idle(3);
    req_valid = 1'b1; req_mode = 2'd1; req_seed = rand_seed();
    idle(8);
    req_valid = 1'b0;
    idle(15);

    // idle request from ACTIVE: halt pulse only
    drive_req(2'd0, '0);
    idle(15);

    // same mode again restarts the full sequence
    drive_req(2'd1, rand_seed());
    idle(12);
    drive_req(2'd1, rand_seed());
    idle(15);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid     = ($urandom % 6) == 0;
      req_mode      = 2'($urandom % 4);
      req_seed      = rand_seed();
      dac_cmd_valid = ($urandom % 5) == 0;
      dac_cmd       = 1'($urandom % 2);
      cycle();
    end
    req_valid = 1'b0; dac_cmd_valid = 1'b0;
    idle(30);

    // reset in the middle of SETTLE
    drive_req(2'd2, '0);
    idle(4);
    do_reset();
    idle(15);
    drive_req(2'd1, rand_seed());
    idle(15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
